// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B, LSB first, through one full-subtractor
// cell with a registered borrow. Results (diff, borrow-out, signed overflow)
// are published together with a one-cycle done pulse and held until the next
// accepted start.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf
);

  localparam int unsigned     CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_ash;
  logic [WIDTH-1:0] r_bsh;
  logic [WIDTH-1:0] r_dsh;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_amsb;
  logic             r_bmsb;

  logic             w_a0;
  logic             w_b0;
  logic             w_d;
  logic             w_bnext;
  logic [WIDTH:0]   w_dcat;
  logic [WIDTH-1:0] w_dsh_next;

  // Full-subtractor cell on the current LSBs plus the working-copy shift.
  // The concatenate-and-drop-LSB form keeps the shift legal for WIDTH=1.
  always_comb begin
    w_a0       = r_ash[0];
    w_b0       = r_bsh[0];
    w_d        = w_a0 ^ w_b0 ^ r_br;
    w_bnext    = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
    w_dcat     = {w_d, r_dsh};
    w_dsh_next = w_dcat[WIDTH:1];
  end

  // Control FSM and datapath registers; results are copied out only on the
  // last bit-step so the visible outputs never toggle while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ash   <= '0;
      r_bsh   <= '0;
      r_dsh   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_amsb  <= 1'b0;
      r_bmsb  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      b_out   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ash   <= a;
            r_bsh   <= b;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_amsb  <= a[WIDTH-1];
            r_bmsb  <= b[WIDTH-1];
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_ash <= r_ash >> 1;
          r_bsh <= r_bsh >> 1;
          r_br  <= w_bnext;
          r_cnt <= r_cnt + 1'b1;
          r_dsh <= w_dsh_next;
          if (r_cnt == LAST) begin
            diff    <= w_dsh_next;
            b_out   <= w_bnext;
            ovf     <= (r_amsb != r_bmsb) & (w_d != r_amsb);
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;

  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8, bout8, ovf8;
  logic [7:0] diff8;

  logic       start1;
  logic [0:0] a1, b1;
  logic       busy1, done1, bout1, ovf1;
  logic [0:0] diff1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .b_out(bout8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .b_out(bout1), .ovf(ovf1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation. With restart=1, start is re-pulsed with a=b=1
  // from mid-RUN through the DONE cycle, and must be ignored.
  task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                     input logic [7:0] ediff, input logic eb, input logic eo,
                     input bit restart);
    logic [7:0] prev;
    int unsigned lat, busyc;
    bit stable;
    @(negedge clk);
    a8 = ta; b8 = tb; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = '0; b8 = '0;
    prev = diff8; lat = 0; busyc = 0; stable = 1'b1;
    if (busy8) busyc++;
    while (!done8 && lat < 20) begin
      if (restart && lat == 3) begin
        start8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
      end
      @(posedge clk); #1;
      lat++;
      if (busy8) busyc++;
      if (!done8 && diff8 !== prev) stable = 1'b0;
    end
    check_eq({tag, " latency"}, lat, 8);
    check_eq({tag, " busy cycles"}, busyc, 8);
    check_eq({tag, " busy at done"}, busy8, 0);
    check_eq({tag, " diff stable in run"}, stable, 1);
    check_eq({tag, " diff"}, diff8, ediff);
    check_eq({tag, " b_out"}, bout8, eb);
    check_eq({tag, " ovf"}, ovf8, eo);
    if (restart) begin
      @(posedge clk); #1;
      start8 = 1'b0;
      @(posedge clk); #1;
      check_eq({tag, " restart ignored busy"}, busy8, 0);
      check_eq({tag, " restart ignored done"}, done8, 0);
      check_eq({tag, " diff held"}, diff8, ediff);
    end else begin
      @(posedge clk); #1;
      check_eq({tag, " done one cycle"}, done8, 0);
    end
  endtask

  // One WIDTH=1 operation: done must appear one edge after RUN's single step.
  task automatic op1(input string tag, input logic ta, input logic tb,
                     input logic ed, input logic eb, input logic eo);
    int unsigned lat;
    @(negedge clk);
    a1 = ta; b1 = tb; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check_eq({tag, " busy"}, busy1, 1);
    lat = 0;
    while (!done1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, " latency"}, lat, 1);
    check_eq({tag, " diff"}, diff1, ed);
    check_eq({tag, " b_out"}, bout1, eb);
    check_eq({tag, " ovf"}, ovf1, eo);
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned seen_done;
    logic [7:0] ra, rb, md;
    logic       mb, mo;

    rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset busy", busy8, 0);
    check_eq("reset done", done8, 0);
    check_eq("reset diff", diff8, 0);
    check_eq("reset b_out", bout8, 0);
    check_eq("reset ovf", ovf8, 0);
    check_eq("reset w1 diff", diff1, 0);
    @(negedge clk);
    rst = 1'b0;

    op8("100-37", 8'd100, 8'd37, 8'd63, 1'b0, 1'b0, 1'b0);
    op8("5-10", 8'd5, 8'd10, 8'hFB, 1'b1, 1'b0, 1'b0);
    op8("0-0", 8'd0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    op8("80-01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    op8("7F-FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
    op8("restart", 8'd100, 8'd37, 8'd63, 1'b0, 1'b0, 1'b1);

    // Abort on the 4th RUN edge.
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd55; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort busy", busy8, 0);
    check_eq("abort done", done8, 0);
    check_eq("abort diff", diff8, 0);
    check_eq("abort b_out", bout8, 0);
    check_eq("abort ovf", ovf8, 0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) seen_done++;
    end
    check_eq("abort no done", seen_done, 0);
    op8("200-55", 8'd200, 8'd55, 8'd145, 1'b0, 1'b0, 1'b0);

    op1("w1 0-0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    op1("w1 0-1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    op1("w1 1-0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    op1("w1 1-1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      {mb, md} = {1'b0, ra} - {1'b0, rb};
      mo = (ra[7] != rb[7]) && (md[7] != ra[7]);
      op8("sweep", ra, rb, md, mb, mo, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
